// File: rtl/spi_slave_pkg.sv
// Shared SPI definitions: default transfer width, select polarity and FSM encoding.
// The same values are used by the master side of the link.
package spi_slave_pkg;

  localparam int   SPI_WIDTH     = 8;
  localparam logic SPI_SS_ACTIVE = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin.
// A third flop keeps the previous synced value, which gives rise and fall strobes.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] pipe;

  always_ff @(posedge clk) begin
    if (rst) pipe <= {3{RESET_VAL}};
    else     pipe <= {pipe[1:0], pin};
  end

  assign level = pipe[1];
  assign rise  = pipe[1] & ~pipe[2];
  assign fall  = ~pipe[1] & pipe[2];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder running entirely on clk: over-samples sclk/mosi/ss,
// shifts a byte in on mosi while shifting one out on miso.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int   WIDTH     = SPI_WIDTH,
  parameter logic SS_ACTIVE = SPI_SS_ACTIVE,
  parameter logic MISO_IDLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ss,
  input  logic [WIDTH-1:0] data_in,
  output logic             miso,
  output logic [WIDTH-1:0] data_out,
  output logic             done,
  output logic             busy,
  output logic             load
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic [1:0] mosi_pipe;
  logic mosi_sync;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // ss resets to the deselected level so leaving reset never fakes a select edge
  spi_sync_edge #(.RESET_VAL(~SS_ACTIVE)) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .pin   (ss),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_pipe <= '0;
    else     mosi_pipe <= {mosi_pipe[0], mosi};
  end
  assign mosi_sync = mosi_pipe[1];

  logic ss_on, ss_off, sclk_up;
  assign ss_on   = (ss_rise | ss_fall) & (ss_level == SS_ACTIVE);
  assign ss_off  = (ss_rise | ss_fall) & (ss_level != SS_ACTIVE);
  assign sclk_up = sclk_rise & sclk_level;

  spi_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] tx_shift, tx_n, rx_shift, rx_n, dout_n;
  logic             done_n, load_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      data_out <= '0;
      done     <= 1'b0;
      load     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tx_shift <= tx_n;
      rx_shift <= rx_n;
      data_out <= dout_n;
      done     <= done_n;
      load     <= load_n;
    end
  end

  // Deselect has priority over any sclk edge in the same cycle.
  // A falling edge with cnt==0 in SHIFT only follows a completed byte: reload.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tx_n    = tx_shift;
    rx_n    = rx_shift;
    dout_n  = data_out;
    done_n  = 1'b0;
    load_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_on) begin
          state_n = SHIFT;
          tx_n    = data_in;
          load_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (ss_off) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (sclk_up) begin
          rx_n = {rx_shift[WIDTH-2:0], mosi_sync};
          if (cnt == CNT_W'(WIDTH - 1)) begin
            dout_n = rx_n;
            done_n = 1'b1;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (cnt == '0) begin
            tx_n   = data_in;
            load_n = 1'b1;
          end else begin
            tx_n = {tx_shift[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign miso = (state == SHIFT) ? tx_shift[WIDTH-1] : MISO_IDLE;
  assign busy = (state == SHIFT);

endmodule
